// File: rtl/register_file_reader.sv
// register_file_reader
//   Register file with one synchronous write port and a two-operand read
//   sequencer (IDLE -> CAPTURE -> VALID) using a request/valid handshake.
//   Sits between instruction decode (issues reads) and the ALU operand latches.
//
//   Optional build macro: REGFILE_WRITE_BYPASS_EN
//     When defined, a write that hits a latched read address on the CAPTURE
//     edge forwards DATA_W into that operand. When undefined, the operand
//     captures the pre-write contents. Write-port behaviour is identical.
//
// Ports
//   C        in   clock, rising edge
//   nR       in   asynchronous active-low reset
//   W        in   write enable
//   ADDR_W   in   write address
//   DATA_W   in   write data
//   RD_REQ   in   read request (accepted in IDLE or VALID)
//   ADDR_R1  in   operand 1 address, latched on accept
//   ADDR_R2  in   operand 2 address, latched on accept
//   RD_BUSY  out  high in CAPTURE; requests are dropped
//   RD_VALID out  one-cycle strobe, DATA_R1/DATA_R2 valid
//   DATA_R1  out  operand 1 (held until the next capture)
//   DATA_R2  out  operand 2 (held until the next capture)
module register_file_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  C,
    input  logic                  nR,
    input  logic                  W,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  RD_REQ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic                  RD_BUSY,
    output logic                  RD_VALID,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    // Storage spans the full address space so every index is in bounds;
    // entries at or above NUM_REGS (and entry 0) are never written and
    // stay at their reset value of zero.
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_L = (ADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CAPTURE, VALID} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd1, rd2;

    // Address names an implemented, writable register (not r0, < NUM_REGS).
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < NUM_REGS_L);
    endfunction

    assign wr_en = W && addr_ok(ADDR_W);

    // ---------------- storage ----------------
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[ADDR_W] <= DATA_W;
        end
    end

    // ---------------- array read at latched addresses ----------------
    always_comb begin
        rd1 = addr_ok(addr1_q) ? regs_q[addr1_q] : '0;
        rd2 = addr_ok(addr2_q) ? regs_q[addr2_q] : '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        // Only consumed on the CAPTURE edge, so this forwards exactly the
        // write that lands on that edge. wr_en already excludes r0/out-of-range.
        if (wr_en && (ADDR_W == addr1_q)) rd1 = DATA_W;
        if (wr_en && (ADDR_W == addr2_q)) rd2 = DATA_W;
`endif
    end

    // ---------------- read sequencer ----------------
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state_q <= IDLE;
            addr1_q <= '0;
            addr2_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state_q <= state_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        RD_BUSY  = 1'b0;
        RD_VALID = 1'b0;
        case (state_q)
            IDLE: begin
                if (RD_REQ) begin
                    addr1_d = ADDR_R1;
                    addr2_d = ADDR_R2;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Requests arriving here are dropped, not queued.
                RD_BUSY = 1'b1;
                data1_d = rd1;
                data2_d = rd2;
                state_d = VALID;
            end
            VALID: begin
                RD_VALID = 1'b1;
                if (RD_REQ) begin
                    addr1_d = ADDR_R1;
                    addr2_d = ADDR_R2;
                    state_d = CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign DATA_R1 = data1_q;
    assign DATA_R2 = data2_q;

endmodule

// File: tb/tb_register_file_reader.sv
// Self-checking bench for register_file_reader: directed test-plan items
// followed by randomized traffic, compared against a transaction-level model.
// NUM_REGS is set below 2**ADDR_WIDTH so out-of-range addresses are exercised.
module tb_register_file_reader;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 24;

  logic          C = 1'b0;
  logic          nR = 1'b0;
  logic          W = 1'b0;
  logic [AW-1:0] ADDR_W = '0;
  logic [DW-1:0] DATA_W = '0;
  logic          RD_REQ = 1'b0;
  logic [AW-1:0] ADDR_R1 = '0;
  logic [AW-1:0] ADDR_R2 = '0;
  logic          RD_BUSY, RD_VALID;
  logic [DW-1:0] DATA_R1, DATA_R2;

  register_file_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .C(C), .nR(nR), .W(W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_REQ(RD_REQ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .RD_BUSY(RD_BUSY), .RD_VALID(RD_VALID), .DATA_R1(DATA_R1), .DATA_R2(DATA_R2)
  );

  always #5 C = ~C;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_reg [32];
  bit            m_pend;     // a read was accepted and awaits its capture edge
  bit            m_strobe;   // the capture happened on the previous edge
  int            m_a1, m_a2;
  logic [DW-1:0] m_d1, m_d2;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pend = 0; m_strobe = 0; m_a1 = 0; m_a2 = 0; m_d1 = '0; m_d2 = '0;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0 || a >= NR) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (W && int'(ADDR_W) == a) return DATA_W;
`endif
    return m_reg[a];
  endfunction

  // Apply one rising edge to the model, using the inputs held across it.
  function automatic void m_edge();
    if (m_pend) begin
      m_d1 = m_read(m_a1);
      m_d2 = m_read(m_a2);
      m_pend = 0;
      m_strobe = 1;
    end else begin
      m_strobe = 0;
      if (RD_REQ) begin
        m_a1 = int'(ADDR_R1);
        m_a2 = int'(ADDR_R2);
        m_pend = 1;
      end
    end
    if (W && ADDR_W != 0 && int'(ADDR_W) < NR) m_reg[ADDR_W] = DATA_W;
  endfunction

  task automatic check_all();
    chk("busy",  {31'b0, RD_BUSY},  {31'b0, m_pend});
    chk("valid", {31'b0, RD_VALID}, {31'b0, m_strobe});
    chk("r1",    DATA_R1, m_d1);
    chk("r2",    DATA_R2, m_d2);
  endtask

  task automatic drive(input bit w, input int aw, input logic [DW-1:0] dw,
                       input bit req, input int a1, input int a2);
    W = w; ADDR_W = AW'(aw); DATA_W = dw;
    RD_REQ = req; ADDR_R1 = AW'(a1); ADDR_R2 = AW'(a2);
  endtask

  task automatic cycle();
    @(posedge C);
    m_edge();
    @(negedge C);
    check_all();
  endtask

  task automatic idle(input int n);
    drive(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    drive(1, a, d, 0, 0, 0);
    cycle();
  endtask

  task automatic rd(input int a1, input int a2);
    drive(0, 0, '0, 1, a1, a2);
    cycle();
    idle(3);
  endtask

  initial begin
    m_reset();
    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31));
      if (i > 0) check_all();
    end
    @(negedge C);
    nR = 1'b1;
    idle(1);

    rd(5, 31);

    wr(3, 32'hDEADBEEF);
    wr(7, 32'h00000001);
    rd(3, 7);

    wr(0, 32'hFFFFFFFF);
    rd(0, 0);

    // Writes and reads beyond NUM_REGS are discarded / read as zero.
    wr(NR, 32'hA5A5A5A5);
    wr(31, 32'h5A5A5A5A);
    rd(NR, 31);
    wr(NR - 1, 32'hCAFEF00D);
    rd(NR - 1, NR - 1);

    // Back-to-back with request held high, addresses alternating.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(0, 0, '0, 1, 3, 7);
      else            drive(0, 0, '0, 1, 7, 3);
      cycle();
    end
    idle(3);

    // Write collision on the capture edge.
    wr(3, 32'h11);
    drive(0, 0, '0, 1, 3, 3);
    cycle();
    drive(1, 3, 32'h22, 0, 0, 0);
    cycle();
    idle(2);
    rd(3, 3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit nar = $urandom_range(0, 1);
      drive($urandom_range(0, 2) == 0, nar ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom,
            $urandom_range(0, 2) != 0,
            nar ? $urandom_range(0, 7) : $urandom_range(0, 31),
            nar ? $urandom_range(0, 7) : $urandom_range(0, 31));
      cycle();
    end
    idle(3);

    // Reset in the middle of CAPTURE.
    wr(3, 32'h33);
    drive(0, 0, '0, 1, 3, 3);
    @(posedge C);
    m_edge();
    #2;
    nR = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge C);
    drive(0, 0, '0, 0, 0, 0);
    check_all();
    nR = 1'b1;
    idle(3);
    rd(3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
